// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared states, constants and helpers for the LDM/STM sequencer
package arm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    LWRITE,
    BASEWB,
    FINISH
  } seq_state_t;

  localparam logic [3:0] BYTE_WR_ALL  = 4'b0000;
  localparam logic [3:0] BYTE_WR_NONE = 4'b1111;
  localparam logic [3:0] PC_NUM       = 4'd15;

  // One-hot mask for a register number, used to retire a bit from the list
  function automatic logic [15:0] reg_bit(input logic [3:0] r);
    return 16'd1 << r;
  endfunction

endpackage

// File: rtl/reg_list_scan.sv
// rtl/reg_list_scan.sv - popcount and lowest-set-bit encoder over a 16-bit register list
module reg_list_scan (
  input  logic [15:0] list,
  output logic [4:0]  count,
  output logic [3:0]  lowest,
  output logic        any
);

  // Walk from r15 down so the last hit left in lowest is the lowest set bit
  always_comb begin
    count  = '0;
    lowest = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) begin
        count  = count + 5'd1;
        lowest = 4'(i);
      end
    end
  end

  assign any = |list;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - multi-cycle LDM/STM block transfer sequencer in front of register_arm
module ldm_stm_sequencer
  import arm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [15:0]           reg_list,
  input  logic [ADDR_WIDTH-1:0] base_num,
  input  logic [DATA_WIDTH-1:0] base_in,
  input  logic                  p_bit,
  input  logic                  u_bit,
  input  logic                  w_bit,
  input  logic                  l_bit,
  input  logic [DATA_WIDTH-1:0] Rd_out,
  output logic [ADDR_WIDTH-1:0] Rd_r_addr,
  output logic [ADDR_WIDTH-1:0] Rd_w_addr,
  output logic [DATA_WIDTH-1:0] Rd_in,
  output logic [3:0]            Rd_byte_w_en,
  output logic [ADDR_WIDTH-1:0] Rn_w_addr,
  output logic [DATA_WIDTH-1:0] Rn_in,
  output logic [3:0]            Rn_byte_w_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  pc_load_valid,
  output logic [DATA_WIDTH-1:0] pc_load_value,
  output logic                  busy,
  output logic                  done
);

  seq_state_t            state;
  logic [15:0]           pending;     // set bits not yet started
  logic [3:0]            cur_reg;
  logic                  l_q;
  logic                  w_q;
  logic                  wb_block;    // LDM with base in list: loaded value wins
  logic [ADDR_WIDTH-1:0] base_num_q;
  logic [DATA_WIDTH-1:0] wb_value;

  logic [15:0]           scan_in;
  logic [4:0]            scan_count;
  logic [3:0]            scan_lowest;
  logic                  scan_any;
  logic [DATA_WIDTH-1:0] four_n;
  logic [DATA_WIDTH-1:0] start_addr;
  logic                  advance;

  // In IDLE the scanner looks at the incoming list; afterwards at what is left
  assign scan_in = (state == IDLE) ? reg_list : pending;

  reg_list_scan u_scan (
    .list   (scan_in),
    .count  (scan_count),
    .lowest (scan_lowest),
    .any    (scan_any)
  );

  assign four_n  = DATA_WIDTH'({scan_count, 2'b00});
  assign advance = ((state == ACCESS) && mem_ack && !l_q) || (state == LWRITE);

  // Store data comes straight from the register file read port
  assign mem_wdata = (mem_req && mem_we) ? Rd_out : '0;

  // Lowest address of the block for each of the four addressing modes
  always_comb begin
    start_addr = base_in;
    case ({p_bit, u_bit})
      2'b01:   start_addr = base_in;
      2'b11:   start_addr = base_in + DATA_WIDTH'(4);
      2'b00:   start_addr = base_in - four_n + DATA_WIDTH'(4);
      default: start_addr = base_in - four_n;
    endcase
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state         <= IDLE;
      pending       <= '0;
      cur_reg       <= '0;
      l_q           <= 1'b0;
      w_q           <= 1'b0;
      wb_block      <= 1'b0;
      base_num_q    <= '0;
      wb_value      <= '0;
      Rd_r_addr     <= '0;
      Rd_w_addr     <= '0;
      Rd_in         <= '0;
      Rd_byte_w_en  <= BYTE_WR_NONE;
      Rn_w_addr     <= '0;
      Rn_in         <= '0;
      Rn_byte_w_en  <= BYTE_WR_NONE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      pc_load_valid <= 1'b0;
      pc_load_value <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      pc_load_valid <= 1'b0;
      Rd_byte_w_en  <= BYTE_WR_NONE;
      Rn_byte_w_en  <= BYTE_WR_NONE;

      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            l_q        <= l_bit;
            w_q        <= w_bit;
            base_num_q <= base_num;
            wb_block   <= l_bit && reg_list[base_num];
            wb_value   <= u_bit ? (base_in + four_n) : (base_in - four_n);
            if (scan_any) begin
              state     <= ACCESS;
              cur_reg   <= scan_lowest;
              Rd_r_addr <= ADDR_WIDTH'(scan_lowest);
              pending   <= reg_list & ~reg_bit(scan_lowest);
              mem_req   <= 1'b1;
              mem_we    <= ~l_bit;
              mem_addr  <= start_addr;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (l_q) begin
              state <= LWRITE;
              if (cur_reg == PC_NUM) begin
                pc_load_valid <= 1'b1;
                pc_load_value <= mem_rdata;
              end else begin
                Rd_w_addr    <= ADDR_WIDTH'(cur_reg);
                Rd_in        <= mem_rdata;
                Rd_byte_w_en <= BYTE_WR_ALL;
              end
            end
          end
        end
        LWRITE: begin
          state <= LWRITE;
        end
        BASEWB: begin
          state <= FINISH;
          done  <= 1'b1;
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Move on to the next listed register, or to base writeback when the list is empty
      if (advance) begin
        if (scan_any) begin
          state     <= ACCESS;
          cur_reg   <= scan_lowest;
          Rd_r_addr <= ADDR_WIDTH'(scan_lowest);
          pending   <= pending & ~reg_bit(scan_lowest);
          mem_req   <= 1'b1;
          mem_we    <= ~l_q;
          mem_addr  <= mem_addr + DATA_WIDTH'(4);
        end else begin
          state <= BASEWB;
          if (w_q && !wb_block) begin
            Rn_w_addr    <= base_num_q;
            Rn_in        <= wb_value;
            Rn_byte_w_en <= BYTE_WR_ALL;
          end
        end
      end
    end
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-cycle sequencer for ARM block data transfer (LDM/STM). It sits directly in front of register_arm.
- Walks the 16-bit register list from r0 upward, one register per transfer.
- Drives the register file's Rd read/write ports for each transferred register and its Rn write port for base writeback.
- Runs a req/ack memory handshake. Banked-mode selection stays inside the register file; the S-bit/user-bank variant is out of scope.

Parameters:
- DATA_WIDTH, 32, data and address width.
- ADDR_WIDTH, 4, register-number width.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- reg_list  in  16  register list; bit i selects ri. Captured on start.
- base_num  in  ADDR_WIDTH  base register number; captured on start.
- base_in  in  DATA_WIDTH  base register value; captured on start.
- p_bit, u_bit, w_bit, l_bit  in  1 each  pre-index, up, writeback, load. Captured on start.
- Rd_out  in  DATA_WIDTH  register file read data, combinational from Rd_r_addr.
- Rd_r_addr  out  ADDR_WIDTH  register read for STM.
- Rd_w_addr  out  ADDR_WIDTH  register written for LDM.
- Rd_in  out  DATA_WIDTH  load data to the register file.
- Rd_byte_w_en  out  4  active-low byte write enables; 4'b0000 = full write, 4'b1111 = no write.
- Rn_w_addr  out  ADDR_WIDTH  base writeback address.
- Rn_in  out  DATA_WIDTH  updated base value.
- Rn_byte_w_en  out  4  active-low, same encoding as Rd_byte_w_en.
- mem_req  out  1  access request.
- mem_we  out  1  1 = store.
- mem_addr  out  DATA_WIDTH  word address.
- mem_wdata  out  DATA_WIDTH  store data.
- mem_ack  in  1  access completes on the rising edge where mem_req and mem_ack are both 1.
- mem_rdata  in  DATA_WIDTH  load data, valid with mem_ack.
- pc_load_valid  out  1  one-cycle pulse when r15 is loaded.
- pc_load_value  out  DATA_WIDTH  loaded PC value.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (Rst low, asynchronous): state IDLE.
  - Rd_byte_w_en and Rn_byte_w_en = 4'b1111.
  - mem_req, mem_we, busy, done and pc_load_valid = 0.
  - All address and data outputs = 0.
  - Reset mid-operation abandons the transfer: no further register writes and no writeback.
- Address arithmetic, with n = popcount(reg_list) and arithmetic modulo 2^32:
  - IA (p=0, u=1): start = base.
  - IB (p=1, u=1): start = base + 4.
  - DA (p=0, u=0): start = base - 4n + 4.
  - DB (p=1, u=0): start = base - 4n.
  - Lowest-numbered register always goes to the lowest address. Each completed transfer adds 4.
  - Writeback value = u ? base + 4n : base - 4n.
- IDLE: on start with n = 0, go to FINISH. No memory access and no writes. done pulses the cycle after start.
- IDLE: on start with n > 0, go to ACCESS with current register = lowest set bit.
- ACCESS:
  - mem_req = 1, mem_we = ~l_bit, mem_addr = current address.
  - Rd_r_addr = current register; mem_wdata = Rd_out.
  - All outputs are held stable until ack.
  - On ack for a store: advance to the next set bit, or go to BASEWB if none remain.
  - On ack for a load: latch mem_rdata and go to LWRITE.
- LWRITE (one cycle):
  - mem_req = 0.
  - If the register is not r15: Rd_w_addr = register, Rd_in = latched data, Rd_byte_w_en = 4'b0000.
  - If the register is r15: no Rd write; pc_load_valid = 1, pc_load_value = data.
  - Then advance to the next set bit, or go to BASEWB.
- BASEWB (one cycle): if w_bit, Rn_w_addr = base_num, Rn_in = writeback value, Rn_byte_w_en = 4'b0000.
  - Writeback is suppressed when l_bit is set and base_num is in reg_list; the loaded value wins.
  - STM with the base in the list stores the original base value.
  - Then go to FINISH.
- FINISH: done = 1 for one cycle, then IDLE.
- start is ignored while busy.
- Latency with zero-wait memory (ack high on the first req cycle), measured from start to done:
  - Load: 2n + 2 cycles.
  - Store: n + 2 cycles.

Decomposition:
- Shared package arm_pkg holds:
  - the state enum (IDLE, ACCESS, LWRITE, BASEWB, FINISH);
  - constants BYTE_WR_ALL = 4'b0000, BYTE_WR_NONE = 4'b1111 and PC_NUM = 15.
- One natural sub-module, reg_list_scan: combinational popcount(16) plus lowest-set-bit priority encoder over the remaining-list mask. The sequencer clears each bit as it completes.

Test Plan:
- STM IA, base r13 = 0x1000, list 0x000F, w = 1, ack tied high, r0..r3 = 0x11..0x44 -> stores 0x11..0x44 to 0x1000, 0x1004, 0x1008, 0x100C. Then Rn_w_addr = 13, Rn_in = 0x1010, Rn_byte_w_en = 0000. done exactly 6 cycles after start.
- LDMDB, base 0x2000, list 0x8006, rdata 0xA1, 0xA2, 0xA3 -> reads 0x1FF4, 0x1FF8, 0x1FFC. r1 = 0xA1 and r2 = 0xA2 written. pc_load_valid pulses with value 0xA3. Rd_w_addr 15 is never written (Rd_byte_w_en stays 1111 in that cycle).
- Empty list -> mem_req never asserted, both byte enables stay 1111, done one cycle after start.
- STM IB, list 0x0001, ack delayed 3 cycles -> mem_req, mem_addr = base + 4 and mem_wdata held stable for 4 cycles. Single transfer only.
- LDM IA, base r4 = 0x3000, list 0x0010, w = 1, rdata 0xBEEF -> r4 = 0xBEEF. No Rn write (Rn_byte_w_en stays 1111).
- Rst driven low during ACCESS of a 4-register LDM -> outputs take reset values immediately. No further Rd or Rn writes after Rst returns high. Next start runs normally.
